// File: rtl/i2cmb_wb_sequencer.sv
// Wishbone master that turns one I2C read/write request into the iicmb_m_wb
// register sequence, waiting on irq and decoding each CMDR response.
module i2cmb_wb_sequencer #(
    parameter int WB_ADDR_WIDTH = 2,
    parameter int WB_DATA_WIDTH = 8,
    parameter int TIMEOUT       = 65535
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic                     req_rw_i,
    input  logic [7:0]               req_bus_i,
    input  logic [6:0]               req_addr_i,
    input  logic [3:0]               req_len_i,
    input  logic [7:0]               wr_data_i,
    input  logic                     wr_valid_i,
    output logic                     wr_ready_o,
    output logic [7:0]               rd_data_o,
    output logic                     rd_valid_o,
    output logic                     done_o,
    output logic [1:0]               status_o,
    output logic                     cyc_o,
    output logic                     stb_o,
    output logic                     we_o,
    output logic [WB_ADDR_WIDTH-1:0] adr_o,
    output logic [WB_DATA_WIDTH-1:0] dat_o,
    input  logic [WB_DATA_WIDTH-1:0] dat_i,
    input  logic                     ack_i,
    input  logic                     irq_i
);

    // state       | meaning
    // S_INIT      | write CSR=0xC0 once after reset
    // S_IDLE      | ready for a request
    // S_BUS_*     | DPR=bus, CMDR=Set Bus
    // S_START_CMD | CMDR=Start
    // S_ADDR_*    | DPR={addr,rw}, CMDR=Write
    // S_WR_*      | wait write byte, DPR=byte, CMDR=Write
    // S_RD_CMD    | CMDR=Read ACK/NAK
    // S_RD_DPR    | read DPR, emit byte
    // S_STOP_CMD  | CMDR=Stop
    // S_WAIT_IRQ  | wait for irq with timeout
    // S_RD_CMDR   | read CMDR and decode response
    typedef enum logic [3:0] {
        S_INIT, S_IDLE, S_BUS_DPR, S_BUS_CMD, S_START_CMD, S_ADDR_DPR, S_ADDR_CMD,
        S_WR_WAIT, S_WR_DPR, S_WR_CMD, S_RD_CMD, S_RD_DPR, S_STOP_CMD, S_WAIT_IRQ, S_RD_CMDR
    } state_t;

    typedef enum logic [2:0] {PH_BUS, PH_START, PH_ADDR, PH_DATA, PH_STOP} phase_t;

    localparam logic [WB_ADDR_WIDTH-1:0] A_CSR  = WB_ADDR_WIDTH'(0);
    localparam logic [WB_ADDR_WIDTH-1:0] A_DPR  = WB_ADDR_WIDTH'(1);
    localparam logic [WB_ADDR_WIDTH-1:0] A_CMDR = WB_ADDR_WIDTH'(2);
    localparam logic [15:0]              TMO_LOAD = 16'(TIMEOUT - 1);

    state_t      state_q, state_d;
    phase_t      phase_q, phase_d;
    logic        rw_q;
    logic [7:0]  bus_q;
    logic [6:0]  addr_q;
    logic [3:0]  len_q, cnt_q;
    logic [7:0]  wr_byte_q;
    logic [15:0] tmo_q;
    logic        gap_q;
    logic [1:0]  pend_q, status_q;
    logic        done_q, rd_valid_q;
    logic [7:0]  rd_data_q;

    logic                     wb_req, wb_we;
    logic [WB_ADDR_WIDTH-1:0] wb_adr;
    logic [WB_DATA_WIDTH-1:0] wb_dat;
    logic                     fin, set_nak, cnt_inc, rd_cap;
    logic [1:0]               fin_status;
    logic                     hs, accept, cmd_last;

    // gap_q forces one idle cycle after every ack (and during reset)
    assign hs       = !gap_q && ack_i;
    assign accept   = (state_q == S_IDLE) && req_valid_i;
    assign cmd_last = (cnt_q == len_q - 4'd1);

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        wb_req     = 1'b0;
        wb_we      = 1'b1;
        wb_adr     = A_CMDR;
        wb_dat     = '0;
        fin        = 1'b0;
        fin_status = 2'b00;
        set_nak    = 1'b0;
        cnt_inc    = 1'b0;
        rd_cap     = 1'b0;
        case (state_q)
            S_INIT: begin
                wb_req = 1'b1; wb_adr = A_CSR; wb_dat = WB_DATA_WIDTH'(8'hC0);
                if (hs) state_d = S_IDLE;
            end
            S_IDLE: if (req_valid_i) state_d = S_BUS_DPR;
            S_BUS_DPR: begin
                wb_req = 1'b1; wb_adr = A_DPR; wb_dat = WB_DATA_WIDTH'(bus_q);
                if (hs) state_d = S_BUS_CMD;
            end
            S_BUS_CMD: begin
                wb_req = 1'b1; wb_dat = WB_DATA_WIDTH'(8'h06);
                if (hs) begin state_d = S_WAIT_IRQ; phase_d = PH_BUS; end
            end
            S_START_CMD: begin
                wb_req = 1'b1; wb_dat = WB_DATA_WIDTH'(8'h04);
                if (hs) begin state_d = S_WAIT_IRQ; phase_d = PH_START; end
            end
            S_ADDR_DPR: begin
                wb_req = 1'b1; wb_adr = A_DPR; wb_dat = WB_DATA_WIDTH'({addr_q, rw_q});
                if (hs) state_d = S_ADDR_CMD;
            end
            S_ADDR_CMD: begin
                wb_req = 1'b1; wb_dat = WB_DATA_WIDTH'(8'h01);
                if (hs) begin state_d = S_WAIT_IRQ; phase_d = PH_ADDR; end
            end
            S_WR_WAIT: if (wr_valid_i) state_d = S_WR_DPR;
            S_WR_DPR: begin
                wb_req = 1'b1; wb_adr = A_DPR; wb_dat = WB_DATA_WIDTH'(wr_byte_q);
                if (hs) state_d = S_WR_CMD;
            end
            S_WR_CMD: begin
                wb_req = 1'b1; wb_dat = WB_DATA_WIDTH'(8'h01);
                if (hs) begin state_d = S_WAIT_IRQ; phase_d = PH_DATA; end
            end
            S_RD_CMD: begin
                wb_req = 1'b1; wb_dat = cmd_last ? WB_DATA_WIDTH'(8'h03) : WB_DATA_WIDTH'(8'h02);
                if (hs) begin state_d = S_WAIT_IRQ; phase_d = PH_DATA; end
            end
            S_RD_DPR: begin
                wb_req = 1'b1; wb_we = 1'b0; wb_adr = A_DPR;
                if (hs) begin
                    rd_cap  = 1'b1;
                    cnt_inc = 1'b1;
                    state_d = cmd_last ? S_STOP_CMD : S_RD_CMD;
                end
            end
            S_STOP_CMD: begin
                wb_req = 1'b1; wb_dat = WB_DATA_WIDTH'(8'h05);
                if (hs) begin state_d = S_WAIT_IRQ; phase_d = PH_STOP; end
            end
            S_WAIT_IRQ: begin
                if (irq_i) state_d = S_RD_CMDR;
                else if (tmo_q == 16'd0) begin fin = 1'b1; fin_status = 2'b11; state_d = S_IDLE; end
            end
            S_RD_CMDR: begin
                wb_req = 1'b1; wb_we = 1'b0;
                if (hs) begin
                    if (dat_i[5]) begin
                        fin = 1'b1; fin_status = 2'b10; state_d = S_IDLE;
                    end else if (dat_i[4]) begin
                        fin = 1'b1; fin_status = 2'b11; state_d = S_IDLE;
                    end else if (phase_q == PH_STOP && (dat_i[6] || dat_i[7])) begin
                        fin = 1'b1; fin_status = pend_q; state_d = S_IDLE;
                    end else if (dat_i[6]) begin
                        set_nak = 1'b1; state_d = S_STOP_CMD;
                    end else if (dat_i[7]) begin
                        case (phase_q)
                            PH_BUS:   state_d = S_START_CMD;
                            PH_START: state_d = S_ADDR_DPR;
                            PH_ADDR:  state_d = (len_q == 4'd0) ? S_STOP_CMD
                                              : (rw_q ? S_RD_CMD : S_WR_WAIT);
                            PH_DATA: begin
                                if (rw_q) state_d = S_RD_DPR;
                                else begin
                                    cnt_inc = 1'b1;
                                    state_d = cmd_last ? S_STOP_CMD : S_WR_WAIT;
                                end
                            end
                            default: begin fin = 1'b1; fin_status = 2'b11; state_d = S_IDLE; end
                        endcase
                    end else begin
                        // a response with no status bit set is treated as a controller error
                        fin = 1'b1; fin_status = 2'b11; state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= S_INIT;
            phase_q    <= PH_BUS;
            rw_q       <= 1'b0;
            bus_q      <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            wr_byte_q  <= '0;
            tmo_q      <= TMO_LOAD;
            gap_q      <= 1'b1;
            pend_q     <= 2'b00;
            status_q   <= 2'b00;
            done_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            gap_q      <= cyc_o && ack_i;
            done_q     <= fin;
            rd_valid_q <= rd_cap;
            if (fin) status_q <= fin_status;
            if (rd_cap) rd_data_q <= dat_i[7:0];
            if (accept) begin
                rw_q   <= req_rw_i;
                bus_q  <= req_bus_i;
                addr_q <= req_addr_i;
                len_q  <= req_len_i;
                cnt_q  <= 4'd0;
                pend_q <= 2'b00;
            end else begin
                if (cnt_inc) cnt_q <= cnt_q + 4'd1;
                if (set_nak) pend_q <= 2'b01;
            end
            if (state_q == S_WR_WAIT && wr_valid_i) wr_byte_q <= wr_data_i;
            if (state_q != S_WAIT_IRQ) tmo_q <= TMO_LOAD;
            else if (tmo_q != 16'd0) tmo_q <= tmo_q - 16'd1;
        end
    end

    assign cyc_o       = wb_req && !gap_q;
    assign stb_o       = cyc_o;
    assign we_o        = cyc_o && wb_we;
    assign adr_o       = cyc_o ? wb_adr : '0;
    assign dat_o       = (cyc_o && wb_we) ? wb_dat : '0;
    assign req_ready_o = (state_q == S_IDLE);
    assign wr_ready_o  = (state_q == S_WR_WAIT);
    assign rd_data_o   = rd_data_q;
    assign rd_valid_o  = rd_valid_q;
    assign done_o      = done_q;
    assign status_o    = status_q;

endmodule

// File: tb/tb_i2cmb_wb_sequencer.sv
// Bench for i2cmb_wb_sequencer: table of request vectors against a small
// iicmb controller model, plus reset, timeout and mid-read reset sequences.
module tb_i2cmb_wb_sequencer;

    logic       clk, rst_n;
    logic       req_valid, req_ready, req_rw;
    logic [7:0] req_bus;
    logic [6:0] req_addr;
    logic [3:0] req_len;
    logic [7:0] wr_data;
    logic       wr_valid, wr_ready;
    logic [7:0] rd_data;
    logic       rd_valid, done;
    logic [1:0] status;
    logic       cyc, stb, we;
    logic [1:0] adr;
    logic [7:0] dat_w;
    logic [7:0] m_dat;
    logic       m_ack, m_irq;

    i2cmb_wb_sequencer #(.WB_ADDR_WIDTH(2), .WB_DATA_WIDTH(8), .TIMEOUT(64)) dut (
        .clk_i(clk), .rst_i(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_rw_i(req_rw),
        .req_bus_i(req_bus), .req_addr_i(req_addr), .req_len_i(req_len),
        .wr_data_i(wr_data), .wr_valid_i(wr_valid), .wr_ready_o(wr_ready),
        .rd_data_o(rd_data), .rd_valid_o(rd_valid), .done_o(done), .status_o(status),
        .cyc_o(cyc), .stb_o(stb), .we_o(we), .adr_o(adr), .dat_o(dat_w),
        .dat_i(m_dat), .ack_i(m_ack), .irq_i(m_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // iicmb controller model
    logic [7:0] m_dpr, m_resp, m_rd_idx, resp;
    logic       m_addr_ph;
    int         m_irq_cnt;
    logic       block_setbus;
    logic [7:0] inj_cmd, inj_resp;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ack <= 1'b0; m_irq <= 1'b0; m_irq_cnt <= 0; m_dat <= '0;
            m_dpr <= '0; m_resp <= '0; m_addr_ph <= 1'b0; m_rd_idx <= '0;
        end else begin
            m_ack <= cyc && stb && !m_ack;
            if (m_irq_cnt == 1) m_irq <= 1'b1;
            if (m_irq_cnt != 0) m_irq_cnt <= m_irq_cnt - 1;
            if (cyc && stb && !m_ack) begin
                if (we) begin
                    if (adr == 2'd1) m_dpr <= dat_w;
                    else if (adr == 2'd2) begin
                        resp = 8'h80;
                        if (dat_w == 8'h04) begin m_addr_ph <= 1'b1; m_rd_idx <= '0; end
                        if (dat_w == 8'h01 && m_addr_ph) begin
                            m_addr_ph <= 1'b0;
                            if (m_dpr[7:1] != 7'h22) resp = 8'h40;
                        end
                        if (inj_cmd != 8'h00 && dat_w == inj_cmd) resp = inj_resp;
                        m_resp <= resp;
                        if (!(block_setbus && dat_w == 8'h06)) m_irq_cnt <= 4;
                    end
                end else begin
                    if (adr == 2'd2) begin m_dat <= m_resp; m_irq <= 1'b0; end
                    else if (adr == 2'd1) begin m_dat <= 8'h10 + m_rd_idx; m_rd_idx <= m_rd_idx + 8'd1; end
                    else m_dat <= '0;
                end
            end
        end
    end

    // monitors
    logic [9:0] wr_log[$];
    logic [7:0] rd_log[$];
    int         done_cnt = 0, gap_err = 0;
    logic       wr_ready_seen, ack_prev;

    initial ack_prev = 1'b0;
    always @(negedge clk) begin
        if (cyc && stb && we && m_ack) wr_log.push_back({adr, dat_w});
        if (rd_valid) rd_log.push_back(rd_data);
        if (done) done_cnt++;
        if (wr_ready) wr_ready_seen = 1'b1;
        if (ack_prev && cyc) gap_err++;
        ack_prev = cyc && m_ack;
    end

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic            rw;
        logic [7:0]      bus;
        logic [6:0]      addr;
        logic [3:0]      len;
        logic [3:0][7:0] wdata;
        logic [7:0]      inj_cmd;
        logic [7:0]      inj_resp;
        logic [1:0]      exp_status;
        logic [4:0]      exp_nwr;
        logic [11:0][9:0] exp_wr;
        logic [2:0]      exp_nrd;
        logic [3:0][7:0] exp_rd;
    } vec_t;

    vec_t vecs[7];

    function automatic vec_t mk(input logic rw, input logic [7:0] bus, input logic [6:0] addr,
                                input logic [3:0] len, input logic [1:0] st);
        vec_t v;
        v = '0;
        v.rw = rw; v.bus = bus; v.addr = addr; v.len = len; v.exp_status = st;
        return v;
    endfunction

    task automatic add_wr(inout vec_t v, input logic [1:0] a, input logic [7:0] d);
        v.exp_wr[v.exp_nwr] = {a, d};
        v.exp_nwr = v.exp_nwr + 5'd1;
    endtask

    task automatic add_rd(inout vec_t v, input logic [7:0] d);
        v.exp_rd[v.exp_nrd] = d;
        v.exp_nrd = v.exp_nrd + 3'd1;
    endtask

    function automatic logic [25:0] outs();
        return {req_ready, wr_ready, rd_data, rd_valid, done, status, cyc, stb, we, adr, dat_w};
    endfunction

    task automatic start_req(input vec_t v);
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 2000) begin @(negedge clk); n++; end
        req_rw = v.rw; req_bus = v.bus; req_addr = v.addr; req_len = v.len;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic feed(input logic [7:0] b, input int pre);
        int n;
        n = 0;
        repeat (pre) @(negedge clk);
        @(negedge clk);
        wr_data = b; wr_valid = 1'b1;
        while (!wr_ready && n < 500) begin @(negedge clk); n++; end
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        int   d0, n, nfeed;
        logic exp_wrr;
        v = vecs[i];
        inj_cmd = v.inj_cmd; inj_resp = v.inj_resp;
        wr_log.delete(); rd_log.delete(); wr_ready_seen = 1'b0;
        d0 = done_cnt;
        exp_wrr = !v.rw && v.len != 4'd0 && v.exp_status == 2'b00;
        nfeed = exp_wrr ? int'(v.len) : 0;
        start_req(v);
        fork
            begin
                for (int k = 0; k < nfeed; k++) feed(v.wdata[k], k);
            end
            begin
                n = 0;
                while (done_cnt == d0 && n < 3000) begin @(negedge clk); n++; end
            end
        join
        repeat (3) @(negedge clk);
        chk($sformatf("v%0d done_count", i), 32'(done_cnt - d0), 32'd1);
        chk($sformatf("v%0d status", i), 32'(status), 32'(v.exp_status));
        chk($sformatf("v%0d req_ready", i), 32'(req_ready), 32'd1);
        chk($sformatf("v%0d wb_write_count", i), 32'(wr_log.size()), 32'(v.exp_nwr));
        for (int k = 0; k < int'(v.exp_nwr); k++)
            if (k < wr_log.size())
                chk($sformatf("v%0d wb_write%0d", i, k), 32'(wr_log[k]), 32'(v.exp_wr[k]));
        chk($sformatf("v%0d rd_count", i), 32'(rd_log.size()), 32'(v.exp_nrd));
        for (int k = 0; k < int'(v.exp_nrd); k++)
            if (k < rd_log.size())
                chk($sformatf("v%0d rd%0d", i, k), 32'(rd_log[k]), 32'(v.exp_rd[k]));
        chk($sformatf("v%0d wr_ready_seen", i), 32'(wr_ready_seen), 32'(exp_wrr));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    initial begin
        vec_t v;
        int   n, d0;

        // 0: write A5,5A to 0x22 on bus 0
        v = mk(1'b0, 8'h00, 7'h22, 4'd2, 2'b00);
        v.wdata[0] = 8'hA5; v.wdata[1] = 8'h5A;
        add_wr(v, 2'd1, 8'h00); add_wr(v, 2'd2, 8'h06); add_wr(v, 2'd2, 8'h04);
        add_wr(v, 2'd1, 8'h44); add_wr(v, 2'd2, 8'h01);
        add_wr(v, 2'd1, 8'hA5); add_wr(v, 2'd2, 8'h01);
        add_wr(v, 2'd1, 8'h5A); add_wr(v, 2'd2, 8'h01); add_wr(v, 2'd2, 8'h05);
        vecs[0] = v;
        // 1: read 3 bytes from 0x22
        v = mk(1'b1, 8'h00, 7'h22, 4'd3, 2'b00);
        add_wr(v, 2'd1, 8'h00); add_wr(v, 2'd2, 8'h06); add_wr(v, 2'd2, 8'h04);
        add_wr(v, 2'd1, 8'h45); add_wr(v, 2'd2, 8'h01);
        add_wr(v, 2'd2, 8'h02); add_wr(v, 2'd2, 8'h02); add_wr(v, 2'd2, 8'h03); add_wr(v, 2'd2, 8'h05);
        add_rd(v, 8'h10); add_rd(v, 8'h11); add_rd(v, 8'h12);
        vecs[1] = v;
        // 2: write to absent 0x30 on bus 1
        v = mk(1'b0, 8'h01, 7'h30, 4'd2, 2'b01);
        add_wr(v, 2'd1, 8'h01); add_wr(v, 2'd2, 8'h06); add_wr(v, 2'd2, 8'h04);
        add_wr(v, 2'd1, 8'h60); add_wr(v, 2'd2, 8'h01); add_wr(v, 2'd2, 8'h05);
        vecs[2] = v;
        // 3: len=0 probe of 0x22 on bus 2
        v = mk(1'b0, 8'h02, 7'h22, 4'd0, 2'b00);
        add_wr(v, 2'd1, 8'h02); add_wr(v, 2'd2, 8'h06); add_wr(v, 2'd2, 8'h04);
        add_wr(v, 2'd1, 8'h44); add_wr(v, 2'd2, 8'h01); add_wr(v, 2'd2, 8'h05);
        vecs[3] = v;
        // 4: arbitration lost on Start, no Stop
        v = mk(1'b0, 8'h00, 7'h22, 4'd1, 2'b10);
        v.inj_cmd = 8'h04; v.inj_resp = 8'h20;
        add_wr(v, 2'd1, 8'h00); add_wr(v, 2'd2, 8'h06); add_wr(v, 2'd2, 8'h04);
        vecs[4] = v;
        // 5: error on first read byte, no Stop and no read data
        v = mk(1'b1, 8'h03, 7'h22, 4'd2, 2'b11);
        v.inj_cmd = 8'h02; v.inj_resp = 8'h10;
        add_wr(v, 2'd1, 8'h03); add_wr(v, 2'd2, 8'h06); add_wr(v, 2'd2, 8'h04);
        add_wr(v, 2'd1, 8'h45); add_wr(v, 2'd2, 8'h01); add_wr(v, 2'd2, 8'h02);
        vecs[5] = v;
        // 6: single-byte read uses the NAK read command directly
        v = mk(1'b1, 8'h00, 7'h22, 4'd1, 2'b00);
        add_wr(v, 2'd1, 8'h00); add_wr(v, 2'd2, 8'h06); add_wr(v, 2'd2, 8'h04);
        add_wr(v, 2'd1, 8'h45); add_wr(v, 2'd2, 8'h01); add_wr(v, 2'd2, 8'h03); add_wr(v, 2'd2, 8'h05);
        add_rd(v, 8'h10);
        vecs[6] = v;

        req_valid = 1'b0; req_rw = 1'b0; req_bus = '0; req_addr = '0; req_len = '0;
        wr_data = '0; wr_valid = 1'b0; block_setbus = 1'b0; inj_cmd = '0; inj_resp = '0;
        wr_ready_seen = 1'b0;

        // reset state and INIT write
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1 chk("reset_outputs", 32'(outs()), 32'd0);
        repeat (2) @(negedge clk);
        wr_log.delete();
        rst_n = 1'b1;
        n = 0;
        while (!req_ready && n < 200) begin @(negedge clk); n++; end
        @(negedge clk);
        chk("init_write_count", 32'(wr_log.size()), 32'd1);
        chk("init_csr_write", 32'(wr_log[0]), 32'h0C0);

        for (int i = 0; i < 7; i++) run_vec(i);

        // Set Bus never answered: 64 cycles in WAIT_IRQ then timeout
        block_setbus = 1'b1; inj_cmd = '0;
        d0 = done_cnt;
        v = mk(1'b0, 8'h00, 7'h22, 4'd1, 2'b11);
        start_req(v);
        n = 0;
        while (!(cyc && m_ack && we && adr == 2'd2 && dat_w == 8'h06) && n < 500) begin
            @(negedge clk); n++;
        end
        n = 0;
        while (!done && n < 300) begin @(negedge clk); n++; end
        chk("timeout_cycles", 32'(n), 32'd65);
        chk("timeout_status", 32'(status), 32'd3);
        chk("timeout_cyc", 32'(cyc), 32'd0);
        chk("timeout_req_ready", 32'(req_ready), 32'd1);
        repeat (2) @(negedge clk);
        chk("timeout_done_count", 32'(done_cnt - d0), 32'd1);
        block_setbus = 1'b0;

        // reset while the second read byte is in flight
        rd_log.delete();
        start_req(vecs[1]);
        n = 0;
        while (rd_log.size() == 0 && n < 2000) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        d0 = done_cnt;
        rst_n = 1'b0;
        #1 chk("midread_reset_outputs", 32'(outs()), 32'd0);
        wr_log.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (!req_ready && n < 200) begin @(negedge clk); n++; end
        repeat (2) @(negedge clk);
        chk("midread_no_done", 32'(done_cnt - d0), 32'd0);
        chk("midread_rd_count", 32'(rd_log.size()), 32'd1);
        chk("midread_reinit_count", 32'(wr_log.size()), 32'd1);
        chk("midread_reinit_csr", 32'(wr_log[0]), 32'h0C0);
        run_vec(1);

        chk("wb_idle_gap_violations", 32'(gap_err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/i2cmb_wb_sequencer.md
# i2cmb_wb_sequencer

Wishbone master that sits directly upstream of the I2C multi-bus controller (iicmb_m_wb). It converts one high-level request into the controller's register-level Wishbone sequence. A request is an I2C write or read of N bytes to a 7-bit address on a selected bus. The block waits on the controller's interrupt and decodes the CMDR response. It streams write data in and read data out, and reports a per-transaction status.

## Interface
Parameters:
- WB_ADDR_WIDTH, 2: Wishbone address width (CSR=0, DPR=1, CMDR=2, FSMR=3).
- WB_DATA_WIDTH, 8: Wishbone data width.
- TIMEOUT, 65535: maximum cycles spent waiting for irq_i per command (16-bit counter).

Ports:
- clk_i, in, 1: clock.
- rst_i, in, 1: reset, asynchronous, active-low.
- req_valid_i, in, 1: request present.
- req_ready_o, out, 1: sequencer idle; a request is accepted when req_valid_i && req_ready_o.
- req_rw_i, in, 1: 0 = write, 1 = read.
- req_bus_i, in, 8: bus index loaded into DPR for Set Bus.
- req_addr_i, in, 7: I2C slave address.
- req_len_i, in, 4: byte count, 0..15.
- wr_data_i, in, 8: write byte.
- wr_valid_i, in, 1: write byte present.
- wr_ready_o, out, 1: high while the block is waiting for a write byte.
- rd_data_o, out, 8: read byte.
- rd_valid_o, out, 1: one-cycle pulse per read byte; no backpressure.
- done_o, out, 1: one-cycle pulse at transaction end.
- status_o, out, 2: 00 ok, 01 NAK, 10 arbitration lost, 11 error/timeout; valid with done_o, held until next done_o.
- cyc_o, stb_o, we_o, out, 1 each: Wishbone master controls.
- adr_o, out, WB_ADDR_WIDTH: Wishbone address.
- dat_o, out, WB_DATA_WIDTH: Wishbone write data.
- dat_i, in, WB_DATA_WIDTH: Wishbone read data.
- ack_i, in, 1: Wishbone acknowledge.
- irq_i, in, 1: controller interrupt.

## Operation
- **Reset:** all outputs are 0 and the FSM enters INIT.
- **INIT:** write CSR=0xC0 (enable and IE), then go to IDLE. INIT is executed once after every reset.
- **IDLE:** req_ready_o=1. On accept, latch rw, bus, addr and len, and clear the byte counter.
- **Command step:** perform the Wishbone write(s), enter WAIT_IRQ, then read CMDR (the read clears irq). Decode the CMDR response by priority:
  - bit5 AL → status 10, go to DONE with no Stop.
  - bit4 ERR → status 11, go to DONE.
  - bit6 NAK → status 01, go to STOP.
  - bit7 DON → continue.
- **Sequence:**
  1. DPR=bus, then CMDR=0x06 (Set Bus).
  2. CMDR=0x04 (Start).
  3. DPR={addr,rw}, then CMDR=0x01 (Write).
  4. Data phase, len iterations:
     - Write: wr_ready_o=1 until wr_valid_i, latch byte, DPR=byte, CMDR=0x01.
     - Read: CMDR=0x02 (read with ACK) for bytes 0..len-2 and 0x03 (read with NAK) for the last byte, then read DPR → rd_data_o with rd_valid_o pulse.
  5. STOP: CMDR=0x05.
  6. DONE: done_o pulse, then IDLE.
- **len=0:** address phase then Stop (address probe); NAK on address gives status 01.
- **Timeout:** the WAIT_IRQ counter reloads on entry. If it reaches TIMEOUT, set status 11, deassert cyc_o/stb_o, go to DONE with no Stop.
- **Read path:** rd_valid_o fires only after a DON response. No rd_valid_o for bytes aborted by an error.
- **Reset mid-transaction:** asynchronous abort with all outputs cleared. No done_o for the aborted request. INIT is re-run.

## Timing
- **Wishbone cycle:**
  - Assert cyc_o, stb_o, we_o, adr_o and dat_o together and hold them stable until ack_i is sampled high.
  - Read data is captured from dat_i on the ack cycle.
  - cyc_o/stb_o deassert on the cycle after ack, and stay low for at least 1 cycle between transfers.
- **Request accept:** the first Wishbone cycle starts on the clock after accept.
- **irq_i:** treated as a level; sampled in WAIT_IRQ only.
- **Write handshake:** a byte is consumed on the edge where wr_valid_i && wr_ready_o. wr_ready_o drops the next cycle.
- **Read output:** rd_valid_o/rd_data_o assert the cycle after the DPR read ack.
- **Completion:** done_o and status_o update the cycle after the final CMDR read ack, or on timeout expiry. req_ready_o rises in the same cycle as done_o.
- **Request while busy:** req_valid_i is ignored while req_ready_o=0; the request must be held.

## Test plan
- **Write 2 bytes to 0x22, bus 0, data 0xA5, 0x5A:**
  - Wishbone writes in order: CSR 0xC0, DPR 0x00, CMDR 0x06, CMDR 0x04, DPR 0x44, CMDR 0x01, DPR 0xA5, CMDR 0x01, DPR 0x5A, CMDR 0x01, CMDR 0x05.
  - done_o pulses once with status 00.
- **Read 3 bytes from 0x22, slave returns 0x10, 0x11, 0x12:**
  - DPR 0x45, then CMDR 0x02, 0x02, 0x03.
  - Three rd_valid_o pulses carrying 0x10, 0x11, 0x12; status 00.
- **Write to absent address 0x30:**
  - Address NAK, then CMDR 0x05 issued.
  - No data-phase writes and wr_ready_o never asserted; status 01.
- **len=0 probe of present slave 0x22:**
  - Start, DPR 0x44, Write, Stop; status 00 and no data handshakes.
- **TIMEOUT=64 with irq_i tied low after Set Bus write:**
  - Exactly 64 cycles in WAIT_IRQ, then done_o with status 11.
  - cyc_o=0 and req_ready_o=1.
- **Reset mid-read (rst_i low during byte 1):**
  - Outputs go to 0 immediately with no done_o.
  - After release, CSR 0xC0 is rewritten and a new request completes normally.
